timer_dev: RTL and testbench

Programmable countdown timer. It is the responder on the processor bus that the multi-cycle `mips` core initiates. It decodes word-addressed register reads and writes, counts down from a preset value, and raises a level interrupt that drives one `HWInt` line into CP0. The system bridge sits between the core's `PrAddr`/`PrDOut`/`Wen`/`PrDIn` and this block's select, write and data ports.

---
 rtl/timer_if.sv | 33 +++
 rtl/timer_dev.sv | 135 +++++++++++++
 tb/tb_timer_dev.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_if.sv
// Processor-bus responder port for the countdown timer: select, write strobe,
// word offset, write/read data and the level interrupt.
interface timer_if;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;

    logic          sel;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          irq;

    // Bridge side drives the access, reads back data and interrupt
    modport master (
        output sel,
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    // Timer side decodes the access, returns data and interrupt
    modport slave (
        input  sel,
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/timer_dev.sv
// Programmable countdown timer: CTRL/PRESET/COUNT register file, a
// load/count/interrupt state machine and a level interrupt (IP & IM).
module timer_dev (
    input  logic    clk,
    input  logic    rst,
    timer_if.slave  bus
);
    localparam int unsigned DW = 32;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_AUTO = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          en_q, en_d;
    logic [1:0]    mode_q, mode_d;
    logic          im_q, im_d;
    logic          ip_q, ip_d;
    logic [DW-1:0] preset_q, preset_d;
    logic [DW-1:0] count_q, count_d;

    logic          wr_c;
    logic          int_entry_c;
    logic          oneshot_done_c;

    assign wr_c = bus.sel & bus.we;

    // State and register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            ip_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            ip_q     <= ip_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    // Next-state: FSM actions first, then bus writes, so a CTRL write beats
    // the one-shot En clear and an INT entry beats the CTRL write's IP clear
    always_comb begin
        state_d        = state_q;
        en_d           = en_q;
        mode_d         = mode_q;
        im_d           = im_q;
        ip_d           = ip_q;
        preset_d       = preset_q;
        count_d        = count_q;
        int_entry_c    = 1'b0;
        oneshot_done_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    state_d     = S_INT;
                    int_entry_c = 1'b1;
                end else begin
                    count_d = count_q - DW'(1);
                end
            end
            S_INT: begin
                if (mode_q == MODE_AUTO) begin
                    state_d = S_LOAD;
                end else begin
                    state_d        = S_IDLE;
                    oneshot_done_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (oneshot_done_c) begin
            en_d = 1'b0;
        end

        if (wr_c && bus.addr == ADDR_CTRL) begin
            en_d   = bus.din[0];
            mode_d = bus.din[2:1];
            im_d   = bus.din[3];
            ip_d   = 1'b0;
        end

        if (wr_c && bus.addr == ADDR_PRESET) begin
            preset_d = bus.din;
        end

        if (int_entry_c) begin
            ip_d = 1'b1;
        end
    end

    // Combinational read mux; offset 3 reads as zero
    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            ADDR_CTRL:   bus.dout = {27'd0, ip_q, im_q, mode_q, en_q};
            ADDR_PRESET: bus.dout = preset_q;
            ADDR_COUNT:  bus.dout = count_q;
            default:     bus.dout = '0;
        endcase
    end

    assign bus.irq = ip_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, disable,
// register map table and write/interrupt collisions.
module tb_timer_dev;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    timer_if bus();

    timer_dev dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [12];

    logic [31:0] ar_cnt [16] = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1,
                                 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.sel  = 1'b1;
        bus.we   = 1'b1;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.dout, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.sel  = 1'b0;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 32'd0;

        // Register map table, applied from an idle timer with COUNT=10
        vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'd10,        1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'd0,         1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 32'h0000_000F, 2'd0, 32'd0,         1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h0000_000F, 2'd0, 32'd0,         1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_000F, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'd0,         2'd2, 32'd10,        1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 32'd0,         2'd2, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'd0,         2'd2, 32'hFFFF_FFFE, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 32'd0,         2'd2, 32'hFFFF_FFFE, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'd0,         2'd0, 32'd0,         1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            rd_chk($sformatf("reset_dout_a%0d", a), 2'(a), 32'd0);
        end
        chk_irq("reset_irq", 1'b0);
        rst = 1'b0;
        tick(1);

        // Asynchronous reset mid-count at COUNT=5
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h9);
        tick(4);
        rd_chk("midrst_pre_count", 2'd2, 32'd5);
        rst = 1'b1;
        rd_chk("midrst_count", 2'd2, 32'd0);
        rd_chk("midrst_ctrl", 2'd0, 32'd0);
        rd_chk("midrst_preset", 2'd1, 32'd0);
        rd_chk("midrst_rsvd", 2'd3, 32'd0);
        chk_irq("midrst_irq", 1'b0);
        rst = 1'b0;
        tick(8);
        chk_irq("midrst_no_irq", 1'b0);
        rd_chk("midrst_idle_count", 2'd2, 32'd0);

        // One-shot, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            rd_chk($sformatf("oneshot_count_e%0d", k + 2), 2'd2, 32'(3 - k));
        end
        tick(1);
        chk_irq("oneshot_irq_e6", 1'b1);
        rd_chk("oneshot_ctrl_e6", 2'd0, 32'h19);
        tick(1);
        rd_chk("oneshot_ctrl_e7", 2'd0, 32'h18);
        chk_irq("oneshot_irq_e7", 1'b1);
        tick(3);
        chk_irq("oneshot_irq_hold", 1'b1);
        wr(2'd0, 32'h0);
        chk_irq("oneshot_irq_clear", 1'b0);
        rd_chk("oneshot_ctrl_clear", 2'd0, 32'h0);

        // Auto-reload, PRESET=2: INT entries at e5, e10, e15
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 16; e++) begin
            tick(1);
            rd_chk($sformatf("auto_count_e%0d", e), 2'd2, ar_cnt[e - 1]);
            chk_irq($sformatf("auto_irq_e%0d", e), (e >= 5) ? 1'b1 : 1'b0);
        end
        wr(2'd0, 32'hB);
        rd_chk("auto_clr_count_e17", 2'd2, 32'd2);
        chk_irq("auto_clr_irq_e17", 1'b0);
        tick(1);
        rd_chk("auto_count_e18", 2'd2, 32'd1);
        tick(1);
        rd_chk("auto_count_e19", 2'd2, 32'd0);
        chk_irq("auto_irq_e19", 1'b0);
        // CTRL write on the INT-entry edge: IP set wins
        wr(2'd0, 32'hB);
        chk_irq("collide_int_irq", 1'b1);
        rd_chk("collide_int_ctrl", 2'd0, 32'h1B);
        wr(2'd0, 32'h0);
        tick(3);
        chk_irq("auto_stop_irq", 1'b0);

        // Disable mid-count, PRESET=10: freeze at 6, reload on re-enable
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick(5);
        rd_chk("dis_count_e5", 2'd2, 32'd7);
        wr(2'd0, 32'h0);
        rd_chk("dis_count_e6", 2'd2, 32'd6);
        tick(3);
        rd_chk("dis_count_frozen", 2'd2, 32'd6);
        chk_irq("dis_irq", 1'b0);
        wr(2'd0, 32'h1);
        tick(1);
        rd_chk("reen_count_r1", 2'd2, 32'd6);
        // Disabling while in LOAD still completes the load
        wr(2'd0, 32'h0);
        rd_chk("reen_count_r2", 2'd2, 32'd10);
        tick(2);
        rd_chk("reen_count_frozen", 2'd2, 32'd10);

        // Register map table
        for (int i = 0; i < 12; i++) begin
            bus.sel  = vecs[i].sel;
            bus.we   = vecs[i].we;
            bus.addr = vecs[i].addr;
            bus.din  = vecs[i].din;
            @(posedge clk);
            #1;
            bus.sel = 1'b0;
            bus.we  = 1'b0;
            rd_chk($sformatf("map_v%0d_dout", i), vecs[i].raddr, vecs[i].exp_dout);
            chk_irq($sformatf("map_v%0d_irq", i), vecs[i].exp_irq);
        end

        // One-shot INT edge combined with CTRL=0x9 write, PRESET=1
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick(3);
        rd_chk("restart_count_e3", 2'd2, 32'd0);
        chk_irq("restart_irq_e3", 1'b0);
        tick(1);
        chk_irq("restart_irq_e4", 1'b1);
        wr(2'd0, 32'h9);
        rd_chk("restart_ctrl_e5", 2'd0, 32'h9);
        chk_irq("restart_irq_e5", 1'b0);
        tick(2);
        rd_chk("restart_count_e7", 2'd2, 32'd1);
        tick(1);
        rd_chk("restart_count_e8", 2'd2, 32'd0);
        chk_irq("restart_irq_e8", 1'b0);
        tick(1);
        chk_irq("restart_irq_e9", 1'b1);
        rd_chk("restart_ctrl_e9", 2'd0, 32'h19);
        tick(1);
        rd_chk("restart_ctrl_e10", 2'd0, 32'h18);
        wr(2'd0, 32'h0);

        // PRESET=0: INT at e3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_irq("zero_irq_e2", 1'b0);
        rd_chk("zero_count_e2", 2'd2, 32'd0);
        tick(1);
        chk_irq("zero_irq_e3", 1'b1);
        rd_chk("zero_ctrl_e3", 2'd0, 32'h19);
        wr(2'd0, 32'h0);
        chk_irq("zero_irq_clear", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
